// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the RV32I multi-cycle control path:
// FSM states, opcodes, ALU ops and datapath mux selects.
package multicycle_control_fsm_pkg;

    typedef enum logic [3:0] {
        S_RESET, S_FETCH, S_DECODE, S_MEMADR,
        S_MEMREAD, S_MEMWRITE, S_MEMWB, S_EXEC_R,
        S_EXEC_I, S_ALUWB, S_BRANCH, S_JAL,
        S_JALR, S_LUI, S_AUIPC, S_ILLEGAL
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_ctrl_t;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_U = 3'b011,
        IMM_J = 3'b100
    } imm_src_t;

    typedef enum logic [1:0] {
        SRCA_PC    = 2'b00,
        SRCA_OLDPC = 2'b01,
        SRCA_REG   = 2'b10,
        SRCA_ZERO  = 2'b11
    } src_a_t;

    typedef enum logic [1:0] {
        SRCB_REG  = 2'b00,
        SRCB_IMM  = 2'b01,
        SRCB_FOUR = 2'b10
    } src_b_t;

    typedef enum logic [1:0] {
        RES_ALUOUT = 2'b00,
        RES_MEM    = 2'b01,
        RES_ALU    = 2'b10
    } result_src_t;

    typedef enum logic [1:0] {
        ALUOP_ADD  = 2'b00,
        ALUOP_SUB  = 2'b01,
        ALUOP_FUNC = 2'b10
    } aluop_t;

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the main FSM and the datapath:
// instruction fields and flags in, enables and selects out.
interface multicycle_control_fsm_if;

    logic [6:0] opcode;
    logic [2:0] func3;
    logic       func7_5;
    logic       alu_zero;
    logic       alu_lt;
    logic       alu_ltu;
    logic       mem_ready;

    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [2:0] imm_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [3:0] alu_control;
    logic       illegal_instr;

    modport master (
        input  opcode, func3, func7_5,
        input  alu_zero, alu_lt, alu_ltu, mem_ready,
        output mem_req, mem_write, adr_src,
        output ir_write, pc_write, reg_write,
        output imm_src, alu_src_a, alu_src_b,
        output result_src, alu_control, illegal_instr
    );

    modport slave (
        output opcode, func3, func7_5,
        output alu_zero, alu_lt, alu_ltu, mem_ready,
        input  mem_req, mem_write, adr_src,
        input  ir_write, pc_write, reg_write,
        input  imm_src, alu_src_a, alu_src_b,
        input  result_src, alu_control, illegal_instr
    );

endinterface

// File: rtl/multicycle_control_fsm_alu_decoder.sv
// Maps the FSM's ALU op class plus func3/func7[5]
// onto the concrete ALU operation.
module multicycle_control_fsm_alu_decoder
    import multicycle_control_fsm_pkg::*;
(
    input  aluop_t      aluop,
    input  logic [2:0]  func3,
    input  logic        func7_5,
    input  logic        is_rtype,
    output alu_ctrl_t   alu_control
);

    // instr[30] only means SUB for R-type; for shifts it means SRA
    always_comb begin
        alu_control = ALU_ADD;
        case (aluop)
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNC: begin
                case (func3)
                    3'b000: alu_control = (is_rtype && func7_5) ? ALU_SUB : ALU_ADD;
                    3'b001: alu_control = ALU_SLL;
                    3'b010: alu_control = ALU_SLT;
                    3'b011: alu_control = ALU_SLTU;
                    3'b100: alu_control = ALU_XOR;
                    3'b101: alu_control = func7_5 ? ALU_SRA : ALU_SRL;
                    3'b110: alu_control = ALU_OR;
                    default: alu_control = ALU_AND;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the RV32I multi-cycle core.
// Sequences one instruction from FETCH to writeback.
module multicycle_control_fsm
    import multicycle_control_fsm_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    multicycle_control_fsm_if.master  bus
);

    state_t      state;
    state_t      state_nx;
    aluop_t      aluop;
    logic        is_rtype;
    logic        taken;
    logic        br_ok;
    imm_src_t    imm_src;
    src_a_t      src_a;
    src_b_t      src_b;
    result_src_t result_src;
    alu_ctrl_t   alu_control;

    // state register; reset drops every output immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_RESET;
        else        state <= state_nx;
    end

    // branch condition from func3 and the comparison flags
    always_comb begin
        taken = 1'b0;
        br_ok = 1'b1;
        case (bus.func3)
            3'b000: taken = bus.alu_zero;
            3'b001: taken = !bus.alu_zero;
            3'b100: taken = bus.alu_lt;
            3'b101: taken = !bus.alu_lt;
            3'b110: taken = bus.alu_ltu;
            3'b111: taken = !bus.alu_ltu;
            default: br_ok = 1'b0;
        endcase
    end

    // next-state: memory states wait on mem_ready
    always_comb begin
        state_nx = state;
        case (state)
            S_RESET:  state_nx = S_FETCH;
            S_FETCH:  if (bus.mem_ready) state_nx = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LOAD,
                    OP_STORE:  state_nx = S_MEMADR;
                    OP_R:      state_nx = S_EXEC_R;
                    OP_I:      state_nx = S_EXEC_I;
                    OP_BRANCH: state_nx = S_BRANCH;
                    OP_JAL:    state_nx = S_JAL;
                    OP_JALR:   state_nx = S_JALR;
                    OP_LUI:    state_nx = S_LUI;
                    OP_AUIPC:  state_nx = S_AUIPC;
                    default:   state_nx = S_ILLEGAL;
                endcase
            end
            S_MEMADR:
                state_nx = (bus.opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (bus.mem_ready) state_nx = S_MEMWB;
            S_MEMWRITE: if (bus.mem_ready) state_nx = S_FETCH;
            S_EXEC_R,
            S_EXEC_I,
            S_JAL,
            S_LUI,
            S_AUIPC:  state_nx = S_ALUWB;
            S_JALR:   state_nx = S_JAL;
            S_BRANCH: state_nx = br_ok ? S_FETCH : S_ILLEGAL;
            S_MEMWB,
            S_ALUWB,
            S_ILLEGAL: state_nx = S_FETCH;
            default:  state_nx = S_RESET;
        endcase
    end

    // Moore output decode; FETCH enables qualified by mem_ready
    always_comb begin
        bus.mem_req       = 1'b0;
        bus.mem_write     = 1'b0;
        bus.adr_src       = 1'b0;
        bus.ir_write      = 1'b0;
        bus.pc_write      = 1'b0;
        bus.reg_write     = 1'b0;
        bus.illegal_instr = 1'b0;
        imm_src           = IMM_I;
        src_a             = SRCA_PC;
        src_b             = SRCB_REG;
        result_src        = RES_ALUOUT;
        aluop             = ALUOP_ADD;
        is_rtype          = 1'b0;
        case (state)
            S_FETCH: begin
                bus.mem_req  = 1'b1;
                src_b        = SRCB_FOUR;
                result_src   = RES_ALU;
                bus.ir_write = bus.mem_ready;
                bus.pc_write = bus.mem_ready;
            end
            S_DECODE: begin
                src_a   = SRCA_OLDPC;
                src_b   = SRCB_IMM;
                imm_src = IMM_B;
            end
            S_MEMADR: begin
                src_a   = SRCA_REG;
                src_b   = SRCB_IMM;
                imm_src = (bus.opcode == OP_STORE) ? IMM_S : IMM_I;
            end
            S_MEMREAD: begin
                bus.mem_req = 1'b1;
                bus.adr_src = 1'b1;
            end
            S_MEMWRITE: begin
                bus.mem_req   = 1'b1;
                bus.adr_src   = 1'b1;
                bus.mem_write = 1'b1;
            end
            S_MEMWB: begin
                bus.reg_write = 1'b1;
                result_src    = RES_MEM;
            end
            S_EXEC_R: begin
                src_a    = SRCA_REG;
                aluop    = ALUOP_FUNC;
                is_rtype = 1'b1;
            end
            S_EXEC_I: begin
                src_a = SRCA_REG;
                src_b = SRCB_IMM;
                aluop = ALUOP_FUNC;
            end
            S_ALUWB: bus.reg_write = 1'b1;
            S_BRANCH: begin
                src_a        = SRCA_REG;
                aluop        = ALUOP_SUB;
                bus.pc_write = br_ok && taken;
            end
            S_JAL: begin
                bus.pc_write = 1'b1;
                src_a        = SRCA_OLDPC;
                src_b        = SRCB_FOUR;
            end
            S_JALR: begin
                bus.pc_write = 1'b1;
                src_a        = SRCA_REG;
                src_b        = SRCB_IMM;
                result_src   = RES_ALU;
            end
            S_LUI: begin
                src_a   = SRCA_ZERO;
                src_b   = SRCB_IMM;
                imm_src = IMM_U;
            end
            S_AUIPC: begin
                src_a   = SRCA_OLDPC;
                src_b   = SRCB_IMM;
                imm_src = IMM_U;
            end
            S_ILLEGAL: bus.illegal_instr = 1'b1;
            default: ;
        endcase
    end

    multicycle_control_fsm_alu_decoder u_alu_dec (
        .aluop       (aluop),
        .func3       (bus.func3),
        .func7_5     (bus.func7_5),
        .is_rtype    (is_rtype),
        .alu_control (alu_control)
    );

    assign bus.imm_src     = imm_src;
    assign bus.alu_src_a   = src_a;
    assign bus.alu_src_b   = src_b;
    assign bus.result_src  = result_src;
    assign bus.alu_control = alu_control;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: per-cycle model of the
// instruction sequence plus hand-computed literal checks.
module tb_multicycle_control_fsm;
    import multicycle_control_fsm_pkg::*;

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       adr_src;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic [2:0] imm_src;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [1:0] result_src;
        logic [3:0] alu;
        logic       illegal;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    multicycle_control_fsm_if bus ();

    multicycle_control_fsm dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int    n_chk = 0;
    int    n_pass = 0;
    int    n_cyc = 0;
    int    n_regw = 0;
    int    n_ill = 0;
    int    n_pcw = 0;
    int    alu_a = -1;
    string cur = "reset";
    obs_t  expq[$];

    function automatic obs_t sample();
        obs_t o;
        o.mem_req    = bus.mem_req;
        o.mem_write  = bus.mem_write;
        o.adr_src    = bus.adr_src;
        o.ir_write   = bus.ir_write;
        o.pc_write   = bus.pc_write;
        o.reg_write  = bus.reg_write;
        o.imm_src    = bus.imm_src;
        o.src_a      = bus.alu_src_a;
        o.src_b      = bus.alu_src_b;
        o.result_src = bus.result_src;
        o.alu        = bus.alu_control;
        o.illegal    = bus.illegal_instr;
        return o;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    // single compare process: DUT against the model queue
    always @(negedge clk) begin : cmp
        obs_t e;
        obs_t a;
        a = sample();
        if (rst_n) begin
            if (a.reg_write) n_regw++;
            if (a.illegal) n_ill++;
            if (a.pc_write) n_pcw++;
            if (a.src_a == 2'b10) alu_a = int'(a.alu);
        end
        if (expq.size() != 0) begin
            e = expq.pop_front();
            n_chk++;
            if (a === e) n_pass++;
            else $display("FAIL %s cycle %0d: got %05h want %05h", cur, n_cyc, a, e);
        end
    end

    // ---- model: expected outputs per phase of an instruction ----
    function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic f7, input logic r);
        alu_ctrl_t t[8];
        t = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
        if (f3 == 3'd0 && r && f7) return ALU_SUB;
        if (f3 == 3'd5 && f7) return ALU_SRA;
        return t[f3];
    endfunction

    function automatic obs_t ph_fetch(input logic r);
        obs_t o = '0;
        o.mem_req = 1'b1;
        o.src_b = 2'b10;
        o.result_src = 2'b10;
        o.ir_write = r;
        o.pc_write = r;
        return o;
    endfunction

    function automatic obs_t ph_ops(input logic [1:0] a, input logic [1:0] b,
                                    input logic [2:0] imm, input logic [3:0] alu);
        obs_t o = '0;
        o.src_a = a;
        o.src_b = b;
        o.imm_src = imm;
        o.alu = alu;
        return o;
    endfunction

    function automatic obs_t ph_wb(input logic [1:0] res);
        obs_t o = '0;
        o.reg_write = 1'b1;
        o.result_src = res;
        return o;
    endfunction

    function automatic obs_t ph_mem(input logic wr);
        obs_t o = '0;
        o.mem_req = 1'b1;
        o.adr_src = 1'b1;
        o.mem_write = wr;
        return o;
    endfunction

    task automatic step(input obs_t e, input logic rdy);
        bus.mem_ready = rdy;
        expq.push_back(e);
        n_cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input string nm, input logic [31:0] ins,
                       input int fw, input int mw,
                       input logic z, input logic lt, input logic ltu,
                       input int lat, input int regw, input int ill,
                       input int pcw, input int alu_exp);
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       cond;
        obs_t       o;
        op = ins[6:0];
        f3 = ins[14:12];
        f7 = ins[30];
        cur = nm;
        bus.opcode = op;
        bus.func3 = f3;
        bus.func7_5 = f7;
        bus.alu_zero = z;
        bus.alu_lt = lt;
        bus.alu_ltu = ltu;
        n_cyc = 0;
        n_regw = 0;
        n_ill = 0;
        n_pcw = 0;
        alu_a = -1;
        for (int i = 0; i < fw; i++) step(ph_fetch(1'b0), 1'b0);
        step(ph_fetch(1'b1), 1'b1);
        step(ph_ops(2'b01, 2'b01, 3'b010, ALU_ADD), 1'b0);
        case (op)
            7'b0110011: begin
                step(ph_ops(2'b10, 2'b00, 3'b000, alu_of(f3, f7, 1'b1)), 1'b0);
                step(ph_wb(2'b00), 1'b0);
            end
            7'b0010011: begin
                step(ph_ops(2'b10, 2'b01, 3'b000, alu_of(f3, f7, 1'b0)), 1'b0);
                step(ph_wb(2'b00), 1'b0);
            end
            7'b0000011, 7'b0100011: begin
                step(ph_ops(2'b10, 2'b01, {2'b00, op[5]}, ALU_ADD), 1'b0);
                for (int i = 0; i < mw; i++) step(ph_mem(op[5]), 1'b0);
                step(ph_mem(op[5]), 1'b1);
                if (!op[5]) step(ph_wb(2'b01), 1'b0);
            end
            7'b1100011: begin
                cond = f3[2] ? (f3[1] ? ltu : lt) : z;
                o = ph_ops(2'b10, 2'b00, 3'b000, ALU_SUB);
                o.pc_write = (f3[2:1] != 2'b01) && (cond ^ f3[0]);
                step(o, 1'b0);
                if (f3[2:1] == 2'b01) begin
                    o = '0;
                    o.illegal = 1'b1;
                    step(o, 1'b0);
                end
            end
            7'b1101111, 7'b1100111: begin
                if (op == 7'b1100111) begin
                    o = ph_ops(2'b10, 2'b01, 3'b000, ALU_ADD);
                    o.pc_write = 1'b1;
                    o.result_src = 2'b10;
                    step(o, 1'b0);
                end
                o = ph_ops(2'b01, 2'b10, 3'b000, ALU_ADD);
                o.pc_write = 1'b1;
                step(o, 1'b0);
                step(ph_wb(2'b00), 1'b0);
            end
            7'b0110111, 7'b0010111: begin
                step(ph_ops(op[5] ? 2'b11 : 2'b01, 2'b01, 3'b011, ALU_ADD), 1'b0);
                step(ph_wb(2'b00), 1'b0);
            end
            default: begin
                o = '0;
                o.illegal = 1'b1;
                step(o, 1'b0);
            end
        endcase
        bus.mem_ready = 1'b0;
        #1;
        chk({nm, "_cycles"}, n_cyc, lat);
        chk({nm, "_back_in_fetch"}, {bus.mem_req, bus.adr_src, bus.ir_write}, 3'b100);
        chk({nm, "_reg_write_pulses"}, n_regw, regw);
        chk({nm, "_illegal_pulses"}, n_ill, ill);
        chk({nm, "_pc_write_pulses"}, n_pcw, pcw);
        if (alu_exp >= 0) chk({nm, "_alu_control"}, alu_a, alu_exp);
        @(posedge clk);
        #1;
        n_cyc = 0;
        expq.push_back(ph_fetch(1'b0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.opcode = '0;
        bus.func3 = '0;
        bus.func7_5 = 1'b0;
        bus.alu_zero = 1'b0;
        bus.alu_lt = 1'b0;
        bus.alu_ltu = 1'b0;
        bus.mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        chk("reset_outputs_zero", 32'(sample()), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step('0, 1'b0);
        chk("first_fetch_after_reset", {bus.mem_req, bus.alu_src_b}, 3'b110);

        //   name      instr         fw mw z  lt ltu lat rw il pcw alu
        run("add",    32'h00208033, 0, 0, 0, 0, 0, 4, 1, 0, 1, ALU_ADD);
        run("sub",    32'h40208033, 0, 0, 0, 0, 0, 4, 1, 0, 1, ALU_SUB);
        run("srai",   32'h4030d093, 0, 0, 0, 0, 0, 4, 1, 0, 1, ALU_SRA);
        run("addi30", 32'h40108093, 0, 0, 0, 0, 0, 4, 1, 0, 1, ALU_ADD);
        run("xor",    32'h0020c033, 1, 0, 0, 0, 0, 5, 1, 0, 1, ALU_XOR);
        run("lw",     32'h0000a103, 3, 2, 0, 0, 0, 10, 1, 0, 1, ALU_ADD);
        run("sw",     32'h0020a023, 0, 1, 0, 0, 0, 5, 0, 0, 1, ALU_ADD);
        run("beq_t",  32'h00208063, 0, 0, 1, 0, 0, 3, 0, 0, 2, ALU_SUB);
        run("beq_n",  32'h00208063, 0, 0, 0, 1, 1, 3, 0, 0, 1, ALU_SUB);
        run("bltu_t", 32'h0020e063, 0, 0, 0, 0, 1, 3, 0, 0, 2, ALU_SUB);
        run("bge_n",  32'h0020d063, 0, 0, 0, 1, 0, 3, 0, 0, 1, ALU_SUB);
        run("br010",  32'h0020a063, 0, 0, 1, 1, 1, 4, 0, 1, 1, ALU_SUB);
        run("jal",    32'h008000ef, 0, 0, 0, 0, 0, 4, 1, 0, 2, -1);
        run("jalr",   32'h000080e7, 0, 0, 0, 0, 0, 5, 1, 0, 3, ALU_ADD);
        run("lui",    32'h123450b7, 0, 0, 0, 0, 0, 4, 1, 0, 1, -1);
        run("auipc",  32'h00000097, 0, 0, 0, 0, 0, 4, 1, 0, 1, -1);
        run("op7f",   32'h0000007f, 0, 0, 0, 0, 0, 3, 0, 1, 1, -1);

        cur = "rst_in_memwrite";
        bus.opcode = 7'b0100011;
        bus.func3 = 3'b010;
        bus.func7_5 = 1'b0;
        n_cyc = 0;
        step(ph_fetch(1'b1), 1'b1);
        step(ph_ops(2'b01, 2'b01, 3'b010, ALU_ADD), 1'b0);
        step(ph_ops(2'b10, 2'b01, 3'b001, ALU_ADD), 1'b0);
        bus.mem_ready = 1'b0;
        #1;
        chk("memwrite_before_reset", {bus.mem_req, bus.mem_write}, 2'b11);
        rst_n = 1'b0;
        #1;
        chk("memwrite_async_drop", 32'(sample()), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step('0, 1'b0);
        chk("fetch_after_mid_reset", {bus.mem_req, bus.adr_src}, 2'b10);
        repeat (2) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
